// File: rtl/md5_search_pkg.sv
// Shared types and block formatting for the md5 nonce search controller.
// Used by md5_search_ctrl and md5_digest_cmp.
package md5_search_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CHECK,
      FOUND,
      DONE,
      TIMEOUT
   } state_t;

   localparam logic [31:0] PAD_WORD1 = 32'h00000080;
   localparam logic [31:0] MSG_BITS  = 32'd32;

   // Single-block message: 32-bit nonce, 0x80 pad byte, bit length in word14
   function automatic logic [511:0] build_block(input logic [31:0] nonce);
      logic [511:0] b;
      b          = '0;
      b[31:0]    = nonce;
      b[63:32]   = PAD_WORD1;
      b[479:448] = MSG_BITS;
      return b;
   endfunction

endpackage

// File: rtl/md5_digest_cmp.sv
// Digest match for the CHECK stage; inputs are already registered.
// MD5_SEARCH_MASK_EN adds a per-bit compare mask.
module md5_digest_cmp (
   input  logic [127:0] dig,
   input  logic [127:0] target,
`ifdef MD5_SEARCH_MASK_EN
   input  logic [127:0] mask,
`endif
   output logic         match
);

`ifdef MD5_SEARCH_MASK_EN
   assign match = ((dig ^ target) & mask) == '0;
`else
   assign match = (dig == target);
`endif

endmodule

// File: rtl/md5_search_ctrl.sv
// Nonce search requester for an md5 core: issues blocks, checks digests.
// Optional MD5_SEARCH_MASK_EN adds target_mask for partial matching.
module md5_search_ctrl
   import md5_search_pkg::*;
#(
   parameter int NONCE_W  = 32,
   parameter int MAX_WAIT = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [NONCE_W-1:0] nonce_base,
   input  logic [NONCE_W-1:0] nonce_last,
   input  logic [127:0]       target,
`ifdef MD5_SEARCH_MASK_EN
   input  logic [127:0]       target_mask,
`endif
   output logic               blk_valid,
   input  logic               blk_ready,
   output logic [511:0]       blk,
   input  logic               dig_valid,
   input  logic [127:0]       dig,
   output logic               busy,
   output logic               found,
   output logic [NONCE_W-1:0] found_nonce,
   output logic               done,
   output logic               timeout,
   output logic [31:0]        hash_count
);

   localparam int WW = $clog2(MAX_WAIT + 1);

   state_t             state, state_d;
   logic [NONCE_W-1:0] cur, last_r;
   logic [127:0]       target_r, dig_r;
   logic [WW-1:0]      wcnt;
   logic               match, wait_hit, at_last, idle_like;

`ifdef MD5_SEARCH_MASK_EN
   logic [127:0]       mask_r;
`endif

   assign idle_like = (state == IDLE) || (state == FOUND) ||
                      (state == DONE) || (state == TIMEOUT);
   assign wait_hit  = (wcnt == WW'(MAX_WAIT - 1));
   // base > last ends after one test instead of wrapping
   assign at_last   = (cur >= last_r);

   md5_digest_cmp u_cmp (
      .dig    (dig_r),
      .target (target_r),
`ifdef MD5_SEARCH_MASK_EN
      .mask   (mask_r),
`endif
      .match  (match)
   );

   always_comb begin
      state_d = state;
      if (stop) begin
         state_d = IDLE;
      end else begin
         unique case (state)
            IDLE, FOUND, DONE, TIMEOUT:
               if (start) state_d = ISSUE;
            ISSUE:
               if (blk_ready) state_d = WAIT;
            WAIT:
               if (dig_valid)     state_d = CHECK;
               else if (wait_hit) state_d = TIMEOUT;
            CHECK:
               if (match)        state_d = FOUND;
               else if (at_last) state_d = DONE;
               else              state_d = ISSUE;
            default:
               state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur         <= '0;
         last_r      <= '0;
         target_r    <= '0;
         dig_r       <= '0;
         wcnt        <= '0;
         found       <= 1'b0;
         found_nonce <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         hash_count  <= '0;
`ifdef MD5_SEARCH_MASK_EN
         mask_r      <= '0;
`endif
      end else if (stop) begin
         found   <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else if (idle_like) begin
         if (start) begin
            cur        <= nonce_base;
            last_r     <= nonce_last;
            target_r   <= target;
`ifdef MD5_SEARCH_MASK_EN
            mask_r     <= target_mask;
`endif
            found      <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            hash_count <= '0;
         end
      end else begin
         unique case (state)
            ISSUE:
               if (blk_ready) wcnt <= '0;
            WAIT: begin
               wcnt <= wcnt + WW'(1);
               // a digest arriving on the last wait cycle still counts
               if (dig_valid)     dig_r   <= dig;
               else if (wait_hit) timeout <= 1'b1;
            end
            CHECK: begin
               if (hash_count != '1) hash_count <= hash_count + 32'd1;
               if (match) begin
                  found       <= 1'b1;
                  found_nonce <= cur;
               end else if (at_last) begin
                  done <= 1'b1;
               end else begin
                  cur <= cur + NONCE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign blk_valid = (state == ISSUE);
   assign blk       = blk_valid ? build_block(32'(cur)) : '0;
   assign busy      = (state == ISSUE) || (state == WAIT) ||
                      (state == CHECK);

endmodule
